ika_timer_bank: RTL and testbench

- Parametrised successor to the fixed two-timer (A/B) unit of the OPM core.
- Provides NUM_TIMERS independent up-counting timers, each with its own load value, prescale divisor, one-shot/auto-reload mode, status flag and IRQ enable.
- Counts on the sample tick, once per 32 phi1 cycles, and drives the REG status flags, the CSM overflow pulse and the chip IRQ.
- Sits beside REG; sees only the phi1 clock-enables and the cycle-31 strobe from TIMINGGEN.

---
 rtl/ika_timer_pkg.sv | 11 +
 rtl/ika_timer_chan.sv | 73 +++++++
 rtl/ika_timer_bank.sv | 64 ++++++
 tb/tb_ika_timer_bank.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ika_timer_pkg.sv
// rtl/ika_timer_pkg.sv - shared constants and packed-slice helpers for the timer bank
package ika_timer_pkg;

  localparam int MAX_TIMERS = 8;

  // Low bit of channel ch within a packed per-channel bus of field width w.
  function automatic int slice_lo(input int ch, input int w);
    return ch * w;
  endfunction

endpackage

// File: rtl/ika_timer_chan.sv
// rtl/ika_timer_chan.sv - one up-counting timer channel with prescaler, flag and overflow pulse
module ika_timer_chan #(
  parameter int CNT_W = 10,
  parameter int PRE_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ncen,
  input  logic             tick,
  input  logic [CNT_W-1:0] load_val,
  input  logic [PRE_W-1:0] div,
  input  logic             run,
  input  logic             oneshot,
  input  logic             flag_en,
  input  logic             flag_rst,
  input  logic             test_fast,
  output logic             flag,
  output logic             ovfl,
  output logic [CNT_W-1:0] cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [PRE_W-1:0] PRE_ONE = PRE_W'(1);

  logic [PRE_W-1:0] pre;
  logic             run_z;
  logic             active;
  logic             count_evt;
  logic             ovf;

  // A count only happens while already running; the rising-edge cycle just loads.
  always_comb begin
    count_evt = tick & active & run & run_z & (test_fast | (pre == div));
    ovf       = count_evt & (&cnt);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      pre    <= '0;
      run_z  <= 1'b0;
      active <= 1'b0;
      flag   <= 1'b0;
      ovfl   <= 1'b0;
    end else if (ncen) begin
      run_z <= run;
      if (run && !run_z) begin
        cnt    <= load_val;
        pre    <= '0;
        active <= 1'b1;
      end else if (!run) begin
        active <= 1'b0;
      end else if (tick && active) begin
        if (count_evt) begin
          pre <= '0;
          if (&cnt) begin
            cnt <= load_val;
            if (oneshot) active <= 1'b0;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end else begin
          // Live DIV compare: a pre above a lowered DIV wraps modulo 2^PRE_W.
          pre <= pre + PRE_ONE;
        end
      end
      if (tick) ovfl <= ovf;
      if (ovf && flag_en) flag <= 1'b1;
      else if (flag_rst) flag <= 1'b0;
    end
  end

endmodule

// File: rtl/ika_timer_bank.sv
// rtl/ika_timer_bank.sv - NUM_TIMERS timer channels plus the registered chip IRQ
module ika_timer_bank
  import ika_timer_pkg::*;
#(
  parameter int NUM_TIMERS = 2,
  parameter int CNT_W      = 10,
  parameter int PRE_W      = 4
) (
  input  logic                        i_EMUCLK,
  input  logic                        i_MRST_n,
  input  logic                        i_phi1_PCEN_n,
  input  logic                        i_phi1_NCEN_n,
  input  logic                        i_CYCLE_31,
  input  logic [NUM_TIMERS*CNT_W-1:0] i_LOAD_VAL,
  input  logic [NUM_TIMERS*PRE_W-1:0] i_DIV,
  input  logic [NUM_TIMERS-1:0]       i_RUN,
  input  logic [NUM_TIMERS-1:0]       i_ONESHOT,
  input  logic [NUM_TIMERS-1:0]       i_FLAG_EN,
  input  logic [NUM_TIMERS-1:0]       i_IRQ_EN,
  input  logic [NUM_TIMERS-1:0]       i_FLAG_RST,
  input  logic                        i_TEST_FAST,
  output logic [NUM_TIMERS-1:0]       o_FLAG,
  output logic [NUM_TIMERS-1:0]       o_OVFL,
  output logic                        o_IRQ_n,
  output logic [NUM_TIMERS*CNT_W-1:0] o_CNT
);

  logic ncen;
  logic tick;
  logic unused_pcen;

  assign ncen        = ~i_phi1_NCEN_n;
  assign tick        = ncen & i_CYCLE_31;
  assign unused_pcen = i_phi1_PCEN_n;

  for (genvar g = 0; g < NUM_TIMERS; g++) begin : g_chan
    ika_timer_chan #(
      .CNT_W(CNT_W),
      .PRE_W(PRE_W)
    ) u_chan (
      .clk      (i_EMUCLK),
      .rst_n    (i_MRST_n),
      .ncen     (ncen),
      .tick     (tick),
      .load_val (i_LOAD_VAL[slice_lo(g, CNT_W) +: CNT_W]),
      .div      (i_DIV[slice_lo(g, PRE_W) +: PRE_W]),
      .run      (i_RUN[g]),
      .oneshot  (i_ONESHOT[g]),
      .flag_en  (i_FLAG_EN[g]),
      .flag_rst (i_FLAG_RST[g]),
      .test_fast(i_TEST_FAST),
      .flag     (o_FLAG[g]),
      .ovfl     (o_OVFL[g]),
      .cnt      (o_CNT[slice_lo(g, CNT_W) +: CNT_W])
    );
  end

  // IRQ follows the flags one NCEN cycle late.
  always_ff @(posedge i_EMUCLK or negedge i_MRST_n) begin
    if (!i_MRST_n) o_IRQ_n <= 1'b1;
    else if (ncen) o_IRQ_n <= ~|(o_FLAG & i_IRQ_EN);
  end

endmodule

// File: tb/tb_ika_timer_bank.sv
// tb/tb_ika_timer_bank.sv - self-checking bench for ika_timer_bank
module tb_ika_timer_bank;

  localparam int N   = 2;
  localparam int CW  = 10;
  localparam int PW  = 4;
  localparam int CMAX = (1 << CW) - 1;
  localparam int PMOD = (1 << PW);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          pcen_n;
  logic          ncen_n;
  logic          c31;
  logic [N*CW-1:0] load_val;
  logic [N*PW-1:0] div;
  logic [N-1:0]  run, oneshot, flag_en, irq_en, flag_rst;
  logic          test_fast;
  logic [N-1:0]  o_flag, o_ovfl;
  logic          o_irq_n;
  logic [N*CW-1:0] o_cnt;

  int errors = 0;
  int checks = 0;

  int m_cnt[N];
  int m_pre[N];
  bit m_act[N], m_runz[N], m_flag[N], m_ovfl[N];
  bit m_irqn;

  ika_timer_bank #(.NUM_TIMERS(N), .CNT_W(CW), .PRE_W(PW)) dut (
    .i_EMUCLK     (clk),
    .i_MRST_n     (rst_n),
    .i_phi1_PCEN_n(pcen_n),
    .i_phi1_NCEN_n(ncen_n),
    .i_CYCLE_31   (c31),
    .i_LOAD_VAL   (load_val),
    .i_DIV        (div),
    .i_RUN        (run),
    .i_ONESHOT    (oneshot),
    .i_FLAG_EN    (flag_en),
    .i_IRQ_EN     (irq_en),
    .i_FLAG_RST   (flag_rst),
    .i_TEST_FAST  (test_fast),
    .o_FLAG       (o_flag),
    .o_OVFL       (o_ovfl),
    .o_IRQ_n      (o_irq_n),
    .o_CNT        (o_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    for (int ch = 0; ch < N; ch++) begin
      m_cnt[ch] = 0; m_pre[ch] = 0; m_act[ch] = 0;
      m_runz[ch] = 0; m_flag[ch] = 0; m_ovfl[ch] = 0;
    end
    m_irqn = 1;
  endtask

  // Reference: applies the timer rules for one NCEN cycle using current inputs.
  task automatic m_step(input bit t);
    bit any;
    bit ovf;
    int lv;
    int dv;
    any = 0;
    for (int ch = 0; ch < N; ch++) if (m_flag[ch] && irq_en[ch]) any = 1;
    m_irqn = !any;
    for (int ch = 0; ch < N; ch++) begin
      lv = int'(load_val[ch*CW +: CW]);
      dv = int'(div[ch*PW +: PW]);
      ovf = 0;
      if (run[ch] && !m_runz[ch]) begin
        m_cnt[ch] = lv; m_pre[ch] = 0; m_act[ch] = 1;
      end else if (!run[ch]) begin
        m_act[ch] = 0;
      end else if (t && m_act[ch]) begin
        if (test_fast || m_pre[ch] == dv) begin
          m_pre[ch] = 0;
          if (m_cnt[ch] == CMAX) begin
            ovf = 1;
            m_cnt[ch] = lv;
            if (oneshot[ch]) m_act[ch] = 0;
          end else begin
            m_cnt[ch] = m_cnt[ch] + 1;
          end
        end else begin
          m_pre[ch] = (m_pre[ch] + 1) % PMOD;
        end
      end
      if (t) m_ovfl[ch] = ovf;
      if (ovf && flag_en[ch]) m_flag[ch] = 1;
      else if (flag_rst[ch]) m_flag[ch] = 0;
      m_runz[ch] = run[ch];
    end
  endtask

  task automatic cmp_model(input string tag);
    logic [N-1:0]    ef, eo;
    logic [N*CW-1:0] ec;
    for (int ch = 0; ch < N; ch++) begin
      ef[ch] = m_flag[ch];
      eo[ch] = m_ovfl[ch];
      ec[ch*CW +: CW] = CW'(m_cnt[ch]);
    end
    chk({tag, ".flag"}, 32'(o_flag), 32'(ef));
    chk({tag, ".ovfl"}, 32'(o_ovfl), 32'(eo));
    chk({tag, ".irq_n"}, 32'(o_irq_n), 32'(m_irqn));
    chk({tag, ".cnt"}, 32'(o_cnt), 32'(ec));
  endtask

  // One NCEN cycle (NCEN low for one clock, then high for one clock).
  task automatic ncen(input bit t);
    ncen_n = 1'b0; c31 = t;
    @(posedge clk);
    m_step(t);
    #1;
    ncen_n = 1'b1; c31 = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) ncen(1'b1);
  endtask

  task automatic set_load(input int ch, input int v);
    load_val[ch*CW +: CW] = CW'(v);
  endtask

  task automatic set_div(input int ch, input int v);
    div[ch*PW +: PW] = PW'(v);
  endtask

  initial begin
    rst_n = 1'b0; pcen_n = 1'b1; ncen_n = 1'b1; c31 = 1'b0;
    load_val = '0; div = '0; run = '0; oneshot = '0; flag_en = '0;
    irq_en = '0; flag_rst = '0; test_fast = 1'b0;
    m_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("reset.flag", 32'(o_flag), 0);
    chk("reset.ovfl", 32'(o_ovfl), 0);
    chk("reset.irq_n", 32'(o_irq_n), 1);
    chk("reset.cnt", 32'(o_cnt), 0);
    rst_n = 1'b1;

    // Auto-reload, period 4 ticks, flag and IRQ path
    set_load(0, 1020); flag_en = 2'b01; irq_en = 2'b11; run = 2'b01;
    ncen(1'b0);
    chk("ar.load", 32'(o_cnt[9:0]), 1020);
    ticks(3);
    chk("ar.pre_ovf_cnt", 32'(o_cnt[9:0]), 1023);
    chk("ar.pre_ovf_ovfl", 32'(o_ovfl[0]), 0);
    ticks(1);
    chk("ar.ovfl", 32'(o_ovfl[0]), 1);
    chk("ar.flag", 32'(o_flag[0]), 1);
    chk("ar.reload", 32'(o_cnt[9:0]), 1020);
    chk("ar.irq_lag", 32'(o_irq_n), 1);
    ncen(1'b0);
    chk("ar.irq", 32'(o_irq_n), 0);
    chk("ar.ovfl_held", 32'(o_ovfl[0]), 1);
    ticks(1);
    chk("ar.ovfl_clr", 32'(o_ovfl[0]), 0);
    ticks(3);
    chk("ar.ovfl2", 32'(o_ovfl[0]), 1);
    flag_rst = 2'b01; ncen(1'b0); flag_rst = 2'b00;
    chk("ar.flag_rst", 32'(o_flag[0]), 0);
    chk("ar.irq_still", 32'(o_irq_n), 0);
    ncen(1'b0);
    chk("ar.irq_release", 32'(o_irq_n), 1);
    cmp_model("ar");

    // One-shot, restart on new RUN edge
    run = 2'b00; ncen(1'b0);
    oneshot = 2'b01; set_load(0, 1022); run = 2'b01; ncen(1'b0);
    ticks(2);
    chk("os.ovfl", 32'(o_ovfl[0]), 1);
    ticks(3);
    chk("os.frozen", 32'(o_cnt[9:0]), 1022);
    chk("os.ovfl_clr", 32'(o_ovfl[0]), 0);
    run = 2'b00; ncen(1'b0); run = 2'b01; ncen(1'b0);
    ticks(1);
    chk("os.restart_mid", 32'(o_ovfl[0]), 0);
    ticks(1);
    chk("os.restart_ovfl", 32'(o_ovfl[0]), 1);
    cmp_model("os");

    // Set beats clear; FLAG_EN=0 still pulses o_OVFL
    flag_rst = 2'b01; ncen(1'b0); flag_rst = 2'b00;
    run = 2'b00; ncen(1'b0); run = 2'b01; ncen(1'b0);
    ticks(1);
    flag_rst = 2'b01; ncen(1'b1); flag_rst = 2'b00;
    chk("setwins.flag", 32'(o_flag[0]), 1);
    flag_rst = 2'b01; ncen(1'b0); flag_rst = 2'b00;
    flag_en = 2'b00;
    run = 2'b00; ncen(1'b0); run = 2'b01; ncen(1'b0);
    ticks(2);
    chk("noflag.ovfl", 32'(o_ovfl[0]), 1);
    chk("noflag.flag", 32'(o_flag[0]), 0);
    cmp_model("flag");
    flag_en = 2'b11; oneshot = 2'b00; run = 2'b00; ncen(1'b0);

    // Ch1 prescaled: (1024-1008)*(15+1) = 256 ticks; TEST_FAST gives 16
    set_load(1, 1008); set_div(1, 15); run = 2'b10; ncen(1'b0);
    ticks(255);
    chk("pre.before", 32'(o_ovfl[1]), 0);
    chk("pre.before_cnt", 32'(o_cnt[19:10]), 1023);
    ticks(1);
    chk("pre.ovfl", 32'(o_ovfl[1]), 1);
    test_fast = 1'b1; run = 2'b00; ncen(1'b0); run = 2'b10; ncen(1'b0);
    ticks(15);
    chk("fast.before", 32'(o_ovfl[1]), 0);
    ticks(1);
    chk("fast.ovfl", 32'(o_ovfl[1]), 1);
    cmp_model("pre");
    test_fast = 1'b0; run = 2'b00; ncen(1'b0);

    // Live LOAD change applies only at the next reload
    set_load(0, 1000); set_div(0, 0); run = 2'b01; ncen(1'b0);
    ticks(10);
    set_load(0, 1020);
    ticks(13);
    chk("ld.before", 32'(o_ovfl[0]), 0);
    ticks(1);
    chk("ld.ovfl", 32'(o_ovfl[0]), 1);
    chk("ld.reload", 32'(o_cnt[9:0]), 1020);
    ticks(3);
    chk("ld.mid", 32'(o_ovfl[0]), 0);
    ticks(1);
    chk("ld.ovfl2", 32'(o_ovfl[0]), 1);
    cmp_model("ld");

    // Async reset mid-count
    run = 2'b00; ncen(1'b0); set_load(0, 490); run = 2'b01; ncen(1'b0);
    ticks(10);
    ncen(1'b0);
    chk("rst.pre_cnt", 32'(o_cnt[9:0]), 500);
    chk("rst.pre_irq", 32'(o_irq_n), 0);
    rst_n = 1'b0;
    #1;
    chk("rst.flag", 32'(o_flag), 0);
    chk("rst.ovfl", 32'(o_ovfl), 0);
    chk("rst.cnt", 32'(o_cnt), 0);
    chk("rst.irq_n", 32'(o_irq_n), 1);
    m_reset();
    run = 2'b00; rst_n = 1'b1;
    ticks(3);
    chk("rst.idle", 32'(o_cnt), 0);
    run = 2'b01; ncen(1'b0);
    chk("rst.restart", 32'(o_cnt[9:0]), 490);
    cmp_model("rst");

    // Randomized traffic against the reference
    for (int it = 0; it < 600; it++) begin
      if (it % 24 == 0) begin
        for (int ch = 0; ch < N; ch++) begin
          set_load(ch, CMAX + 1 - int'($urandom_range(1, 6)));
          set_div(ch, int'($urandom_range(0, 3)));
        end
        oneshot   = N'($urandom);
        flag_en   = N'($urandom);
        irq_en    = N'($urandom);
        test_fast = ($urandom_range(0, 4) == 0);
      end
      for (int ch = 0; ch < N; ch++) begin
        if ($urandom_range(0, 9) == 0) run[ch] = ~run[ch];
        flag_rst[ch] = ($urandom_range(0, 7) == 0);
      end
      ncen($urandom_range(0, 2) == 0);
      cmp_model("rnd");
    end
    flag_rst = '0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
